// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS channel encoder: control tokens, pipeline depth
// and the disparity bound that the encoding algorithm guarantees.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  localparam int TMDS_LATENCY = 3;
  localparam int DISP_MAX     = 8;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_popcount.sv
// Combinational ones-counter for an 8-bit word (result 0..8).
module tmds_popcount (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, data_i[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// One-channel TMDS 8b/10b encoder, three register stages (S1 popcount, S2
// transition-minimised word, S3 DC-balance select and running disparity).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       pixel_clk,
  input  logic       sys_rst,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  input  logic [7:0] din,
  output logic [9:0] dout
);

  if (CNT_W < 5) begin : g_cnt_w_check
    $error("tmds_encoder: CNT_W must be at least 5");
  end

  // S1: input capture and data popcount
  logic [7:0] din_s1_q;
  logic       de_s1_q;
  logic [1:0] c_s1_q;
  logic [3:0] n1d_s1_q;
  logic [3:0] n1d_d;

  tmds_popcount u_pop_din (
    .data_i  (din),
    .count_o (n1d_d)
  );

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      din_s1_q <= '0;
      de_s1_q  <= 1'b0;
      c_s1_q   <= '0;
      n1d_s1_q <= '0;
    end else begin
      din_s1_q <= din;
      de_s1_q  <= de;
      c_s1_q   <= {c1, c0};
      n1d_s1_q <= n1d_d;
    end
  end

  // S2: transition minimisation
  logic       xnor_mode;
  logic [8:0] qm_d;
  logic [3:0] n1q_d;
  logic [3:0] n0q_d;
  logic [8:0] qm_s2_q;
  logic [3:0] n1q_s2_q;
  logic [3:0] n0q_s2_q;
  logic       de_s2_q;
  logic [1:0] c_s2_q;

  assign xnor_mode = (n1d_s1_q > 4'd4) || ((n1d_s1_q == 4'd4) && !din_s1_q[0]);

  always_comb begin
    qm_d    = '0;
    qm_d[0] = din_s1_q[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = xnor_mode ? ~(qm_d[i-1] ^ din_s1_q[i]) : (qm_d[i-1] ^ din_s1_q[i]);
    end
    qm_d[8] = ~xnor_mode;
  end

  tmds_popcount u_pop_qm (
    .data_i  (qm_d[7:0]),
    .count_o (n1q_d)
  );

  assign n0q_d = 4'd8 - n1q_d;

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      qm_s2_q  <= '0;
      n1q_s2_q <= '0;
      n0q_s2_q <= '0;
      de_s2_q  <= 1'b0;
      c_s2_q   <= '0;
    end else begin
      qm_s2_q  <= qm_d;
      n1q_s2_q <= n1q_d;
      n0q_s2_q <= n0q_d;
      de_s2_q  <= de_s1_q;
      c_s2_q   <= c_s1_q;
    end
  end

  // S3: DC balancing; popcounts are zero-extended before going signed
  logic signed [CNT_W-1:0] n1_s;
  logic signed [CNT_W-1:0] n0_s;
  logic signed [CNT_W-1:0] diff_s;
  logic signed [CNT_W-1:0] two_s;
  logic signed [CNT_W-1:0] cnt_q;
  logic signed [CNT_W-1:0] cnt_d;
  logic [9:0]              dout_q;
  logic [9:0]              dout_d;
  logic                    qm8;
  logic                    cnt_zero;
  logic                    cnt_neg;

  assign n1_s     = {{(CNT_W-4){1'b0}}, n1q_s2_q};
  assign n0_s     = {{(CNT_W-4){1'b0}}, n0q_s2_q};
  assign diff_s   = n1_s - n0_s;
  assign two_s    = {{(CNT_W-2){1'b0}}, 2'b10};
  assign qm8      = qm_s2_q[8];
  assign cnt_zero = (cnt_q == '0);
  assign cnt_neg  = cnt_q[CNT_W-1];

  always_comb begin
    dout_d = ctrl_token(c_s2_q);
    cnt_d  = '0;
    if (de_s2_q) begin
      if (cnt_zero || (n1q_s2_q == n0q_s2_q)) begin
        dout_d = {~qm8, qm8, (qm8 ? qm_s2_q[7:0] : ~qm_s2_q[7:0])};
        cnt_d  = qm8 ? (cnt_q + diff_s) : (cnt_q - diff_s);
      end else if ((!cnt_neg && (n1q_s2_q > n0q_s2_q)) ||
                   (cnt_neg && (n0q_s2_q > n1q_s2_q))) begin
        dout_d = {1'b1, qm8, ~qm_s2_q[7:0]};
        cnt_d  = cnt_q + (qm8 ? two_s : '0) - diff_s;
      end else begin
        dout_d = {1'b0, qm8, qm_s2_q[7:0]};
        cnt_d  = cnt_q + diff_s - (qm8 ? '0 : two_s);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: hand-computed vector table, mid-stream reset sequence,
// and a behavioural-model scoreboard for alternating-DE and random soak traffic.
module tb_tmds_encoder;
  import tmds_pkg::*;

  logic       pixel_clk = 1'b0;
  logic       sys_rst;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] din;
  logic [9:0] dout;

  tmds_encoder #(.CNT_W(5)) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .de        (de),
    .c0        (c0),
    .c1        (c1),
    .din       (din),
    .dout      (dout)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] dout;
    int         cnt;
  } exp_t;

  exp_t pipe[$];
  exp_t cur_exp;
  int   m_cnt = 0;
  bit   check_model = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n++;
    return n;
  endfunction

  // Behavioural reference; advances m_cnt in input order
  function automatic logic [9:0] ref_encode(input bit d_e, input bit k1, input bit k0,
                                            input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    int         n1, ones, zeros;
    bit         use_xnor;
    if (!d_e) begin
      m_cnt = 0;
      case ({k1, k0})
        2'b00:   o = 10'h354;
        2'b01:   o = 10'h0AB;
        2'b10:   o = 10'h154;
        default: o = 10'h2AB;
      endcase
      return o;
    end
    n1       = ones8(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    ones  = ones8(qm[7:0]);
    zeros = 8 - ones;
    if (m_cnt == 0 || ones == zeros) begin
      if (qm[8]) begin
        o = {2'b01, qm[7:0]};
        m_cnt = m_cnt + ones - zeros;
      end else begin
        o = {2'b10, ~qm[7:0]};
        m_cnt = m_cnt + zeros - ones;
      end
    end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      m_cnt = m_cnt + (qm[8] ? 2 : 0) + zeros - ones;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      m_cnt = m_cnt + ones - zeros - (qm[8] ? 0 : 2);
    end
    return o;
  endfunction

  // Drive one input set, step one edge, then look at the outputs on the falling edge
  task automatic tick(input bit r, input bit d_e, input bit k1, input bit k0, input logic [7:0] d);
    logic [9:0] o;
    int         act_cnt;
    sys_rst = r;
    de      = d_e;
    c1      = k1;
    c0      = k0;
    din     = d;
    @(posedge pixel_clk);
    if (r) begin
      m_cnt = 0;
      pipe.delete();
      pipe.push_back('{10'h354, 0});
      pipe.push_back('{10'h354, 0});
      cur_exp = '{10'h000, 0};
    end else begin
      o = ref_encode(d_e, k1, k0, d);
      pipe.push_back('{o, m_cnt});
      if (pipe.size() > 0) cur_exp = pipe.pop_front();
    end
    @(negedge pixel_clk);
    if (check_model) begin
      act_cnt = int'(dut.cnt_q);
      check("model dout", int'(dout), int'(cur_exp.dout));
      check("model cnt", act_cnt, cur_exp.cnt);
      check("cnt bound", int'(act_cnt >= -DISP_MAX && act_cnt <= DISP_MAX), 1);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         de;
    bit         c1;
    bit         c0;
    logic [7:0] din;
    logic [9:0] exp_dout;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int burst;
    bit cur_de;

    sys_rst = 1'b1; de = 1'b0; c0 = 1'b0; c1 = 1'b0; din = '0;

    // Expected output on each row belongs to the input two rows earlier
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 10'h000,  0};
    vecs[1]  = '{1, 0, 0, 0, 8'h00, 10'h000,  0};
    vecs[2]  = '{0, 0, 0, 0, 8'h00, 10'h354,  0};
    vecs[3]  = '{0, 0, 0, 1, 8'h00, 10'h354,  0};
    vecs[4]  = '{0, 0, 1, 0, 8'h00, 10'h354,  0};
    vecs[5]  = '{0, 0, 1, 1, 8'h00, 10'h0AB,  0};
    vecs[6]  = '{0, 1, 0, 0, 8'h00, 10'h154,  0};
    vecs[7]  = '{0, 1, 0, 0, 8'h00, 10'h2AB,  0};
    vecs[8]  = '{0, 0, 0, 0, 8'h00, 10'h100, -8};
    vecs[9]  = '{0, 1, 0, 0, 8'hFF, 10'h3FF,  2};
    vecs[10] = '{0, 0, 0, 0, 8'h00, 10'h354,  0};
    vecs[11] = '{0, 1, 0, 0, 8'hAA, 10'h200, -8};
    vecs[12] = '{0, 0, 0, 1, 8'h00, 10'h354,  0};
    vecs[13] = '{0, 1, 0, 0, 8'h55, 10'h233,  0};
    vecs[14] = '{0, 1, 0, 0, 8'h00, 10'h0AB,  0};
    vecs[15] = '{0, 1, 0, 0, 8'hFF, 10'h133,  0};
    vecs[16] = '{0, 1, 0, 0, 8'h01, 10'h100, -8};
    vecs[17] = '{0, 0, 1, 1, 8'h00, 10'h0FF, -2};
    vecs[18] = '{0, 0, 0, 0, 8'h00, 10'h1FF,  6};
    vecs[19] = '{0, 0, 0, 0, 8'h00, 10'h2AB,  0};
    vecs[20] = '{0, 0, 0, 0, 8'h00, 10'h354,  0};
    vecs[21] = '{0, 0, 0, 0, 8'h00, 10'h354,  0};

    @(negedge pixel_clk);
    for (int i = 0; i < 22; i++) begin
      tick(vecs[i].rst, vecs[i].de, vecs[i].c1, vecs[i].c0, vecs[i].din);
      check($sformatf("vec%0d dout", i), int'(dout), int'(vecs[i].exp_dout));
      check($sformatf("vec%0d cnt", i), int'(dut.cnt_q), vecs[i].exp_cnt);
    end

    // Mid-stream reset discards in-flight data
    tick(0, 1, 0, 0, 8'h00);
    tick(0, 1, 0, 0, 8'h00);
    tick(1, 1, 0, 0, 8'hFF);
    check("rst0 dout", int'(dout), 10'h000);
    check("rst0 cnt", int'(dut.cnt_q), 0);
    tick(1, 1, 0, 0, 8'hFF);
    check("rst1 dout", int'(dout), 10'h000);
    check("rst1 cnt", int'(dut.cnt_q), 0);
    tick(0, 0, 0, 1, 8'h00);
    check("post rst +1", int'(dout), 10'h354);
    tick(0, 0, 1, 0, 8'h00);
    check("post rst +2", int'(dout), 10'h354);
    tick(0, 0, 0, 0, 8'h00);
    check("post rst +3", int'(dout), 10'h0AB);
    tick(0, 0, 0, 0, 8'h00);
    check("post rst +4", int'(dout), 10'h154);

    // Alternating DE with AA/55, then random bursts, against the model
    check_model = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) tick(0, 1, 0, 0, (i % 4 == 0) ? 8'hAA : 8'h55);
      else            tick(0, 0, 1'(i / 2), 1'(i / 4), 8'hC3);
    end

    burst  = 0;
    cur_de = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (burst == 0) begin
        cur_de = ($urandom_range(0, 3) != 0);
        burst  = cur_de ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      burst--;
      tick(0, cur_de, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    check_model = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
